passive_arming_ctrl: RTL and testbench
======================================

# passive_arming_ctrl

Sequential arming controller for the passive-security datapath. It watches the same vehicle inputs as the passive alarm block (ignition, door, lights) together with that block's combinational PassiveSignal. It runs a timed arm / entry-delay / alarm sequence and drives registered status outputs for the siren and indicators. It sits between the raw sensor inputs and the output drivers, one instance per vehicle.

## Interface
- ARM_DELAY, 16: cycles from entering ARMING to ARMED (1..2^CNT_W)
- ENTRY_DELAY, 8: cycles in ENTRY before ALARM (1..2^CNT_W)
- ALARM_TIME, 32: cycles the siren sounds per trigger (1..2^CNT_W)
- CNT_W, 8: delay counter width
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- IgnitionSignalOn  input  1  ignition on
- OpenDoorSign  input  1  any door open
- CarLightsOnSign  input  1  headlights on
- PassiveSignal  input  1  lights-left-on indication from the passive block
- DisarmReq  input  1  valid key/remote disarm, 1-cycle pulse or level
- Armed  output  1  high in ARMED, ENTRY and ALARM
- ArmPending  output  1  high in ARMING
- EntryWarn  output  1  high in ENTRY
- Siren  output  1  high in ALARM
- LightsWarn  output  1  lights-on chime (see Configuration)
- State  output  3  current state code

## Operation
- States and codes: DISARMED=0, ARMING=1, ARMED=2, ENTRY=3, ALARM=4. Codes 5–7 are illegal and recover to DISARMED on the next edge.
- Signal definitions:
  - idle = ~IgnitionSignalOn & ~OpenDoorSign.
  - trig = (OpenDoorSign | IgnitionSignalOn) & ~trig_q, where trig_q is the registered OR of the two inputs (rising edge).
- DisarmReq has highest priority. From any state, DisarmReq → DISARMED and the counter clears.
- DISARMED:
  - idle (and arm not blocked, see Configuration) → ARMING; counter loads ARM_DELAY-1.
- ARMING:
  - ~idle → DISARMED (arming aborted).
  - counter==0 → ARMED.
  - Otherwise the counter decrements.
- ARMED:
  - trig → ENTRY; counter loads ENTRY_DELAY-1.
  - A door already open at arming time does not trigger. Only a new rising edge triggers.
- ENTRY:
  - counter==0 → ALARM; counter loads ALARM_TIME-1.
  - Inputs are ignored in ENTRY; only DisarmReq exits.
- ALARM:
  - counter==0 → ARMED (re-arm silently).
  - Re-triggering requires a fresh rising edge of door/ignition.
  - trig during ALARM does not extend the alarm.
- Counter arithmetic: unsigned CNT_W bits, decrement only, never wraps. Loads take priority over decrement.
- Outputs are pure decodes of the state register, so they are glitch-free and registered.

## Timing
- Reset values: State=DISARMED, counter=0, trig_q=0, and every output is 0.
- Reset is asynchronous assert and synchronous-safe release. Reset mid-sequence aborts immediately to DISARMED.
- Inputs are sampled on the rising edge. The state change is visible one cycle after the sampled condition.
- ArmPending lasts exactly ARM_DELAY cycles, then Armed rises.
- EntryWarn lasts exactly ENTRY_DELAY cycles, then Siren rises.
- Siren lasts exactly ALARM_TIME cycles, then the block returns to ARMED.
- DisarmReq coincident with counter==0 wins. For example, in ENTRY it goes to DISARMED, never to ALARM.
- ~idle coincident with counter==0 in ARMING goes to DISARMED.
- trig_q updates every cycle in every state, including DISARMED, so there is no stale edge after arming.

## Configuration
- Macro: PASSIVE_LIGHTS_WARN_EN.
- Defined:
  - LightsWarn = registered PassiveSignal, one cycle latency, forced 0 in ARMED/ENTRY/ALARM.
  - PassiveSignal high blocks DISARMED→ARMING and aborts ARMING to DISARMED, so a car with lights left on is never armed.
- Undefined:
  - LightsWarn is tied 0.
  - PassiveSignal and CarLightsOnSign are ignored; arming depends only on idle.

## Test plan
- Reset: hold reset_n=0 with all inputs at 1 → State=0 and every output 0. Release with ignition=0 and door=0 → ArmPending=1 next cycle for 16 cycles, then Armed=1.
- Abort: while ARMING at count 10, assert OpenDoorSign → next cycle State=0 and ArmPending=0. Deassert it → arming restarts with a full 16 cycles.
- Entry with disarm: in ARMED, pulse OpenDoorSign → EntryWarn=1 for 8 cycles. DisarmReq on the 8th cycle → State=0, Siren never asserts.
- Full alarm: in ARMED, door 0→1 and held → 8 cycles of EntryWarn, then Siren=1 for exactly 32 cycles, then State=ARMED with Siren=0 and no retrigger while the door stays open. Close then reopen the door → ENTRY.
- Config with PASSIVE_LIGHTS_WARN_EN defined: PassiveSignal=1 with ignition=0 and door=0 → stays DISARMED, LightsWarn=1 one cycle after. Without the macro → arms after 16 cycles, LightsWarn=0.
- Mid-operation reset: assert reset_n=0 asynchronously during ALARM → Siren drops without waiting for a clock edge, State=0.

Source files
------------

// File: rtl/passive_arming_ctrl.sv
// Timed arm / entry-delay / alarm sequencer for the passive-security datapath.
// Optional lights-left-on chime and arm inhibit: define PASSIVE_LIGHTS_WARN_EN.
module passive_arming_ctrl #(
  parameter int ARM_DELAY   = 16,
  parameter int ENTRY_DELAY = 8,
  parameter int ALARM_TIME  = 32,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       IgnitionSignalOn,
  input  logic       OpenDoorSign,
  input  logic       CarLightsOnSign,
  input  logic       PassiveSignal,
  input  logic       DisarmReq,
  output logic       Armed,
  output logic       ArmPending,
  output logic       EntryWarn,
  output logic       Siren,
  output logic       LightsWarn,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_ARMING   = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ARM_LOAD   = CNT_W'(ARM_DELAY - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(ALARM_TIME - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic             r_trigQ;
  logic             w_anyOpen;
  logic             w_idle;
  logic             w_trig;
  logic             w_armBlock;
  logic             w_cntZero;
  logic             w_unused;

  assign w_anyOpen = OpenDoorSign | IgnitionSignalOn;
  assign w_idle    = ~w_anyOpen;
  assign w_trig    = w_anyOpen & ~r_trigQ;
  assign w_cntZero = (r_cnt == '0);

`ifdef PASSIVE_LIGHTS_WARN_EN
  logic r_passiveQ;

  assign w_armBlock = PassiveSignal;
  assign w_unused   = CarLightsOnSign;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_passiveQ <= 1'b0;
    else          r_passiveQ <= PassiveSignal;
  end

  assign LightsWarn = r_passiveQ & ~Armed;
`else
  assign w_armBlock = 1'b0;
  assign w_unused   = CarLightsOnSign ^ PassiveSignal;
  assign LightsWarn = 1'b0;
`endif

  // trig_q tracks door/ignition in every state so arming never sees a stale edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_DISARMED;
      r_cnt   <= '0;
      r_trigQ <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_trigQ <= w_anyOpen;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    if (DisarmReq) begin
      w_nextState = S_DISARMED;
      w_nextCnt   = '0;
    end else begin
      case (r_state)
        S_DISARMED: begin
          if (w_idle && !w_armBlock) begin
            w_nextState = S_ARMING;
            w_nextCnt   = ARM_LOAD;
          end
        end
        S_ARMING: begin
          if (!w_idle || w_armBlock) begin
            w_nextState = S_DISARMED;
            w_nextCnt   = '0;
          end else if (w_cntZero) begin
            w_nextState = S_ARMED;
          end else begin
            w_nextCnt = r_cnt - CNT_W'(1);
          end
        end
        S_ARMED: begin
          if (w_trig) begin
            w_nextState = S_ENTRY;
            w_nextCnt   = ENTRY_LOAD;
          end
        end
        S_ENTRY: begin
          if (w_cntZero) begin
            w_nextState = S_ALARM;
            w_nextCnt   = ALARM_LOAD;
          end else begin
            w_nextCnt = r_cnt - CNT_W'(1);
          end
        end
        S_ALARM: begin
          if (w_cntZero) begin
            w_nextState = S_ARMED;
          end else begin
            w_nextCnt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_nextState = S_DISARMED;
          w_nextCnt   = '0;
        end
      endcase
    end
  end

  assign Armed      = (r_state == S_ARMED) || (r_state == S_ENTRY) || (r_state == S_ALARM);
  assign ArmPending = (r_state == S_ARMING);
  assign EntryWarn  = (r_state == S_ENTRY);
  assign Siren      = (r_state == S_ALARM);
  assign State      = r_state;

endmodule

// File: tb/tb_passive_arming_ctrl.sv
// Scoreboard bench for passive_arming_ctrl: stimulus queues expected state/outputs per cycle,
// a monitor pops and compares on each falling clock edge and on asynchronous reset assertion.
module tb_passive_arming_ctrl;

  localparam logic [2:0] ST_DIS   = 3'd0;
  localparam logic [2:0] ST_ARMNG = 3'd1;
  localparam logic [2:0] ST_ARMED = 3'd2;
  localparam logic [2:0] ST_ENTRY = 3'd3;
  localparam logic [2:0] ST_ALARM = 3'd4;

  // Output pattern order: {Armed, ArmPending, EntryWarn, Siren, LightsWarn}
  localparam logic [4:0] O_DIS   = 5'b00000;
  localparam logic [4:0] O_ARMNG = 5'b01000;
  localparam logic [4:0] O_ARMED = 5'b10000;
  localparam logic [4:0] O_ENTRY = 5'b10100;
  localparam logic [4:0] O_ALARM = 5'b10010;

  typedef struct {
    int         tag;
    bit         isAsync;
    logic [2:0] st;
    logic [4:0] outs;
    string      nm;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       IgnitionSignalOn;
  logic       OpenDoorSign;
  logic       CarLightsOnSign;
  logic       PassiveSignal;
  logic       DisarmReq;
  logic       Armed;
  logic       ArmPending;
  logic       EntryWarn;
  logic       Siren;
  logic       LightsWarn;
  logic [2:0] State;

  exp_t expQ[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  passive_arming_ctrl dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .IgnitionSignalOn (IgnitionSignalOn),
    .OpenDoorSign     (OpenDoorSign),
    .CarLightsOnSign  (CarLightsOnSign),
    .PassiveSignal    (PassiveSignal),
    .DisarmReq        (DisarmReq),
    .Armed            (Armed),
    .ArmPending       (ArmPending),
    .EntryWarn        (EntryWarn),
    .Siren            (Siren),
    .LightsWarn       (LightsWarn),
    .State            (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic applyStimulus(input logic ign, input logic door, input logic lights,
                               input logic passive, input logic disarm);
    IgnitionSignalOn = ign;
    OpenDoorSign     = door;
    CarLightsOnSign  = lights;
    PassiveSignal    = passive;
    DisarmReq        = disarm;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expectAt(input int offset, input logic [2:0] st, input logic [4:0] outs,
                          input string nm);
    exp_t e;
    e.tag     = cyc + offset;
    e.isAsync = 1'b0;
    e.st      = st;
    e.outs    = outs;
    e.nm      = nm;
    expQ.push_back(e);
  endtask

  task automatic expectAsync(input logic [2:0] st, input logic [4:0] outs, input string nm);
    exp_t e;
    e.tag     = cyc;
    e.isAsync = 1'b1;
    e.st      = st;
    e.outs    = outs;
    e.nm      = nm;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [4:0] act;
    act = {Armed, ArmPending, EntryWarn, Siren, LightsWarn};
    checks++;
    if (State !== e.st || act !== e.outs) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got State=%0d outs=%b, expected State=%0d outs=%b",
               e.nm, cyc, State, act, e.st, e.outs);
    end
  endtask

  // Monitor: async entries are consumed only while reset is asserted, sync entries by cycle tag.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or negedge reset_n);
      #1;
      if (expQ.size() > 0 && expQ[0].isAsync && !reset_n) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
      while (expQ.size() > 0 && !expQ[0].isAsync && expQ[0].tag <= cyc) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d expectations pending", expQ.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    applyStimulus(1, 1, 1, 1, 1);
    waitCycles(1);
    expectAt(0, ST_DIS, O_DIS, "reset_hold0");
    expectAt(1, ST_DIS, O_DIS, "reset_hold1");
    waitCycles(2);

    // Release with car idle: 16 cycles of ArmPending, then Armed.
    applyStimulus(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    expectAt(1, ST_ARMNG, O_ARMNG, "arm_start");
    expectAt(16, ST_ARMNG, O_ARMNG, "arm_last");
    expectAt(17, ST_ARMED, O_ARMED, "armed");
    waitCycles(17);

    applyStimulus(0, 0, 0, 0, 1);
    expectAt(1, ST_DIS, O_DIS, "disarm");
    waitCycles(1);
    applyStimulus(0, 0, 0, 0, 0);
    expectAt(1, ST_ARMNG, O_ARMNG, "rearm");
    waitCycles(6);

    // Counter is 10 here; opening a door aborts arming, closing restarts it in full.
    applyStimulus(0, 1, 0, 0, 0);
    expectAt(1, ST_DIS, O_DIS, "abort");
    waitCycles(1);
    applyStimulus(0, 0, 0, 0, 0);
    expectAt(1, ST_ARMNG, O_ARMNG, "restart");
    expectAt(16, ST_ARMNG, O_ARMNG, "restart_last");
    expectAt(17, ST_ARMED, O_ARMED, "restart_armed");
    waitCycles(17);

    // Door pulse starts ENTRY; disarm on its 8th cycle must beat the alarm.
    applyStimulus(0, 1, 0, 0, 0);
    expectAt(1, ST_ENTRY, O_ENTRY, "entry_start");
    waitCycles(1);
    applyStimulus(0, 0, 0, 0, 0);
    expectAt(7, ST_ENTRY, O_ENTRY, "entry_last");
    waitCycles(7);
    applyStimulus(0, 0, 0, 0, 1);
    expectAt(1, ST_DIS, O_DIS, "disarm_wins");
    expectAt(2, ST_DIS, O_DIS, "no_siren");
    waitCycles(2);
    applyStimulus(0, 0, 0, 0, 0);
    expectAt(17, ST_ARMED, O_ARMED, "armed2");
    waitCycles(17);

    // Door opened and held: 8 ENTRY, 32 ALARM, back to ARMED with no retrigger.
    applyStimulus(0, 1, 0, 0, 0);
    expectAt(1, ST_ENTRY, O_ENTRY, "alarm_entry");
    expectAt(8, ST_ENTRY, O_ENTRY, "alarm_entry_last");
    expectAt(9, ST_ALARM, O_ALARM, "siren_on");
    expectAt(40, ST_ALARM, O_ALARM, "siren_last");
    expectAt(41, ST_ARMED, O_ARMED, "rearmed");
    expectAt(46, ST_ARMED, O_ARMED, "no_retrigger");
    waitCycles(46);
    applyStimulus(0, 0, 0, 0, 0);
    expectAt(1, ST_ARMED, O_ARMED, "door_closed");
    waitCycles(1);
    applyStimulus(0, 1, 0, 0, 0);
    expectAt(1, ST_ENTRY, O_ENTRY, "retrigger");
    expectAt(9, ST_ALARM, O_ALARM, "alarm2");
    waitCycles(11);

    // Reset asserted mid-cycle during ALARM must clear outputs before the next edge.
    #1;
    expectAsync(ST_DIS, O_DIS, "async_reset");
    reset_n = 1'b0;
    expectAt(1, ST_DIS, O_DIS, "reset_held");
    waitCycles(2);

    // Lights left on at release.
    applyStimulus(0, 0, 0, 1, 0);
    reset_n = 1'b1;
`ifdef PASSIVE_LIGHTS_WARN_EN
    expectAt(1, ST_DIS, 5'b00001, "lights_block");
    expectAt(5, ST_DIS, 5'b00001, "lights_block_hold");
    waitCycles(5);
    applyStimulus(0, 0, 0, 0, 0);
    expectAt(1, ST_ARMNG, O_ARMNG, "lights_off_arm");
    expectAt(17, ST_ARMED, O_ARMED, "lights_off_armed");
    waitCycles(17);
`else
    expectAt(1, ST_ARMNG, O_ARMNG, "lights_ignored");
    expectAt(16, ST_ARMNG, O_ARMNG, "lights_ignored_last");
    expectAt(17, ST_ARMED, O_ARMED, "lights_armed");
    waitCycles(17);
`endif

    for (int i = 0; i < 20 && expQ.size() > 0; i++) waitCycles(1);
    while (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s: expectation for cycle %0d never compared, now cycle %0d",
               e.nm, e.tag, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
